// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-master SRAM arbiter: FSM state encoding,
// master index type and the default access length.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } SramArbState_t;

  // 0 = instruction master, 1 = data master
  typedef logic master_idx_t;

  localparam int unsigned SRAM_ARB_WAIT_DEF = 2;

endpackage

// File: rtl/sram_grant_sel.sv
// Combinational grant selection between the two SRAM masters.
module sram_grant_sel
  import sram_arbiter_pkg::*;
(
  input  logic [1:0]  req,
  input  master_idx_t ptr,
  output master_idx_t grant
);

  // On contention the master not granted last time wins; a pointer tied to 0
  // therefore degenerates into fixed m1-over-m0 priority.
  always_comb begin
    if (req[0] && req[1]) grant = ~ptr;
    else                  grant = req[1];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter for an asynchronous SRAM with a fixed WAIT-cycle access.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of m1-first priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WAIT   = SRAM_ARB_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DATA_W/8-1:0]   m0_be,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DATA_W/8-1:0]   m1_be,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_ack,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_dout,
  input  logic [DATA_W-1:0]     sram_din,
  output logic                  sram_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(WAIT + 1);

  if (WAIT < 1 || WAIT > 15) begin : g_wait_check
    $error("sram_arbiter: WAIT must lie in 1..15");
  end

  // Reset asserts asynchronously but releases through two flops.
  logic rst_sync_q1, rst_sync_q2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q1 <= 1'b0;
      rst_sync_q2 <= 1'b0;
    end else begin
      rst_sync_q1 <= 1'b1;
      rst_sync_q2 <= rst_sync_q1;
    end
  end

  SramArbState_t     state;
  master_idx_t       owner;
  master_idx_t       grant;
  master_idx_t       rr_ptr;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        req_vec;
  logic              start;

  assign req_vec = {m1_req, m0_req};
  assign start   = (state == IDLE) && rst_sync_q2 && (|req_vec);

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_ptr <= 1'b0;
    else if (start) rr_ptr <= grant;
  end
`else
  assign rr_ptr = 1'b0;
`endif

  sram_grant_sel u_grant_sel (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    sel_we    = m0_we;
    sel_be    = m0_be;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant) begin
      sel_we    = m1_we;
      sel_be    = m1_be;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= '0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_oe   <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            owner     <= grant;
            we_q      <= sel_we;
            cnt       <= CNT_W'(WAIT - 1);
            sram_addr <= sel_addr;
            sram_dout <= sel_wdata;
            sram_be_n <= ~sel_be;
            sram_ce_n <= 1'b0;
            sram_oe_n <= sel_we;
            sram_we_n <= ~sel_we;
            sram_oe   <= sel_we;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner) m1_rdata <= sram_din;
              else       m0_rdata <= sram_din;
            end
            if (owner) m1_ack <= 1'b1;
            else       m0_ack <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // Write data stays driven through this cycle for SRAM hold time.
          sram_oe <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
